// File: rtl/picosoc_iobus_pkg.sv
// Shared definitions for the picosoc iomem bus fabric.
//   iobus_state_t           - transaction FSM states (IDLE/REQ/ERR/RESP)
//   IOBUS_ERR_RDATA_DEFAULT - default read data returned on error responses
//   iobus_clog2()           - ceil(log2(n)) with a floor of 1, for index/counter widths
package picosoc_iobus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ERR  = 2'd2,
        ST_RESP = 2'd3
    } iobus_state_t;

    localparam logic [31:0] IOBUS_ERR_RDATA_DEFAULT = 32'hBADB_AD00;

    // Smallest w with 2**w >= n, but never less than 1 so that
    // single-entry selectors and counters still get a real bit.
    function automatic int unsigned iobus_clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/picosoc_iobus_timer.sv
// Bus timeout counter for picosoc_iobus.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear (takes priority over en)
//   en         : count one cycle
//   done       : count has reached TIMEOUT_CYCLES; never set when TIMEOUT_CYCLES == 0
module picosoc_iobus_timer
    import picosoc_iobus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int unsigned CNT_W = iobus_clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (TIMEOUT_CYCLES != 0) && (count == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/picosoc_iobus.sv
// iomem bus fabric between the CPU iomem_* port and NUM_SLAVES peripherals.
// One address region starting at BASE_ADDR is split into equal windows of
// 2**SLAVE_ADDR_W bytes; each accepted request is registered and forwarded to
// one slave. Unpopulated windows and slaves that stay silent for
// TIMEOUT_CYCLES get an error response carrying ERR_RDATA.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   m_valid/m_ready        master request (held until m_ready) / one-cycle response strobe
//   m_wstrb/m_addr/m_wdata master request; m_wstrb == 0 is a read
//   m_rdata                response data, held until the next response
//   s_valid[N]             one-hot slave request
//   s_ready[N]             per-slave ready
//   s_wstrb/s_addr/s_wdata registered request, shared by all slaves
//   s_rdata[32*N]          slave i read data at [32*i +: 32]
//   err_pending/err_addr   sticky error flag / address of first unlogged error
//   err_clr                clears err_pending
//
// Build option: define PICOSOC_IOBUS_ERRLOG_EN to enable the error log;
// otherwise err_pending/err_addr are tied to 0 and err_clr is ignored.
module picosoc_iobus
    import picosoc_iobus_pkg::*;
#(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned SLAVE_ADDR_W   = 8,
    parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = IOBUS_ERR_RDATA_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic [3:0]               m_wstrb,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    output logic [31:0]              m_rdata,
    output logic [NUM_SLAVES-1:0]    s_valid,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    output logic [3:0]               s_wstrb,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    output logic                     err_pending,
    output logic [31:0]              err_addr,
    input  logic                     err_clr
);

    localparam int unsigned IDX_W   = iobus_clog2(NUM_SLAVES);
    localparam int unsigned TAG_LSB = SLAVE_ADDR_W + IDX_W;

    iobus_state_t          state;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_q;
    logic                  hit;
    logic                  idx_ok;
    logic [NUM_SLAVES-1:0] onehot;
    logic                  sel_ready;
    logic [31:0]           sel_rdata;
    logic [31:0]           rdata_q;
    logic                  tmr_done;

    assign hit    = (m_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign idx    = m_addr[SLAVE_ADDR_W +: IDX_W];
    assign idx_ok = ({1'b0, idx} < (IDX_W + 1)'(NUM_SLAVES));

    // Request decode uses the live address; response select uses the
    // captured index so the master may change m_addr after acceptance.
    always_comb begin
        onehot    = '0;
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            onehot[i] = (idx == IDX_W'(i));
            if (idx_q == IDX_W'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    picosoc_iobus_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clr  (state == ST_RESP),
        .en   (state == ST_REQ),
        .done (tmr_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            m_ready <= 1'b0;
            m_rdata <= '0;
            s_valid <= '0;
            s_wstrb <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
        end else begin
            m_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // m_ready high means the master has not yet seen the
                    // response and its m_valid still belongs to the old request.
                    if (m_valid && hit && !m_ready) begin
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_wstrb <= m_wstrb;
                        idx_q   <= idx;
                        if (idx_ok) begin
                            s_valid <= onehot;
                            state   <= ST_REQ;
                        end else begin
                            state   <= ST_ERR;
                        end
                    end
                end
                ST_REQ: begin
                    if (sel_ready) begin
                        rdata_q <= (s_wstrb != 4'd0) ? 32'd0 : sel_rdata;
                        s_valid <= '0;
                        state   <= ST_RESP;
                    end else if (tmr_done) begin
                        s_valid <= '0;
                        state   <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    rdata_q <= ERR_RDATA;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    m_ready <= 1'b1;
                    m_rdata <= rdata_q;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PICOSOC_IOBUS_ERRLOG_EN
    // The ERR state is visited exactly once per error, so it is the log event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_pending <= 1'b0;
            err_addr    <= '0;
        end else if (state == ST_ERR) begin
            err_pending <= 1'b1;
            if (!err_pending) begin
                err_addr <= s_addr;
            end
        end else if (err_clr) begin
            err_pending <= 1'b0;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_pending    = 1'b0;
    assign err_addr       = '0;
`endif

endmodule

// File: tb/tb_picosoc_iobus.sv
module tb_picosoc_iobus;

    localparam int          NS   = 3;
    localparam int          SAW  = 8;
    localparam int          IDXW = 2;
    localparam int          TO   = 255;
    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam logic [31:0] ERRD = 32'hBADB_AD00;
`ifdef PICOSOC_IOBUS_ERRLOG_EN
    localparam bit ERRLOG = 1'b1;
`else
    localparam bit ERRLOG = 1'b0;
`endif

    logic              clk     = 1'b0;
    logic              reset   = 1'b1;
    logic              m_valid = 1'b0;
    logic              m_ready;
    logic [3:0]        m_wstrb = '0;
    logic [31:0]       m_addr  = '0;
    logic [31:0]       m_wdata = '0;
    logic [31:0]       m_rdata;
    logic [NS-1:0]     s_valid;
    logic [NS-1:0]     s_ready = '0;
    logic [3:0]        s_wstrb;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [32*NS-1:0]  s_rdata = '0;
    logic              err_pending;
    logic [31:0]       err_addr;
    logic              err_clr = 1'b0;

    // expected outputs (after the next rising edge)
    logic              exp_m_ready = 1'b0;
    logic [NS-1:0]     exp_s_valid = '0;
    logic [31:0]       exp_m_rdata = '0;
    logic [31:0]       exp_s_addr  = '0;
    logic [31:0]       exp_s_wdata = '0;
    logic [3:0]        exp_s_wstrb = '0;
    logic              mdl_pend    = 1'b0;
    logic [31:0]       mdl_eaddr   = '0;

    int tests = 0;
    int fails = 0;
    int sv_high = 0;
    logic [NS-1:0] last_sv = '0;
    bit clr_noise = 1'b0;

    always #5 clk = ~clk;

    picosoc_iobus #(
        .NUM_SLAVES    (NS),
        .SLAVE_ADDR_W  (SAW),
        .BASE_ADDR     (BASE),
        .TIMEOUT_CYCLES(TO),
        .ERR_RDATA     (ERRD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_wstrb    (m_wstrb),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_wstrb    (s_wstrb),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_rdata    (s_rdata),
        .err_pending(err_pending),
        .err_addr   (err_addr),
        .err_clr    (err_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Single compare process: every cycle, DUT outputs against the model.
    always @(posedge clk) begin
        #1;
        chk("m_ready", 32'(m_ready), 32'(exp_m_ready));
        chk("s_valid", 32'(s_valid), 32'(exp_s_valid));
        chk("m_rdata", m_rdata, exp_m_rdata);
        chk("s_addr", s_addr, exp_s_addr);
        chk("s_wdata", s_wdata, exp_s_wdata);
        chk("s_wstrb", 32'(s_wstrb), 32'(exp_s_wstrb));
        chk("err_pending", 32'(err_pending), ERRLOG ? 32'(mdl_pend) : 32'd0);
        chk("err_addr", err_addr, ERRLOG ? mdl_eaddr : 32'd0);
        if (s_valid != '0) begin
            sv_high++;
            last_sv = s_valid;
        end
    end

    // Error-log rule for the coming edge; err_clr is the value driven this cycle.
    task automatic model_step(input bit ev, input logic [31:0] a);
        if (ev) begin
            if (!mdl_pend) mdl_eaddr = a;
            mdl_pend = 1'b1;
        end else if (err_clr) begin
            mdl_pend = 1'b0;
        end
    endtask

    task automatic drive_noise();
        for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = $urandom;
        s_ready = NS'($urandom);
        err_clr = clr_noise && ($urandom_range(0, 7) == 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            model_step(1'b0, '0);
            @(negedge clk);
            drive_noise();
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        model_step(1'b0, '0);
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // Called at a falling edge. lat < 0: slave never answers.
    // abort_at > 0: assert reset in that cycle of the transaction.
    task automatic do_txn(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                          input int lat, input bit fix_rd, input logic [31:0] rd, input int abort_at);
        bit hit, is_err, is_to;
        int idx, resp_k, last_k;
        logic [NS-1:0] oh;
        logic [31:0] resp_data;
        hit = ((addr >> (SAW + IDXW)) == (BASE >> (SAW + IDXW)));
        idx = int'((addr >> SAW) % (32'd1 << IDXW));
        m_valid = 1'b1;
        m_addr  = addr;
        m_wstrb = wstrb;
        m_wdata = wdata;
        if (!hit) begin
            idle(6);
            m_valid = 1'b0;
            return;
        end
        is_err = (idx >= NS);
        is_to  = !is_err && (lat < 0 || lat > TO);
        resp_k = is_err ? 3 : (is_to ? TO + 4 : lat + 3);
        last_k = is_err ? 0 : (is_to ? TO + 1 : lat + 1);
        oh = '0;
        if (!is_err) oh[idx] = 1'b1;
        resp_data = ERRD;
        for (int k = 1; k <= resp_k; k++) begin
            model_step((is_err || is_to) && (k == resp_k - 1), addr);
            exp_s_valid = (k <= last_k) ? oh : '0;
            exp_m_ready = (k == resp_k);
            if (k == resp_k) exp_m_rdata = resp_data;
            if (k == 1) begin
                exp_s_addr  = addr;
                exp_s_wdata = wdata;
                exp_s_wstrb = wstrb;
            end
            @(negedge clk);
            if (k == abort_at) begin
                #2;
                reset = 1'b1;
                m_valid = 1'b0; s_ready = '0; err_clr = 1'b0;
                exp_m_ready = 1'b0; exp_s_valid = '0; exp_m_rdata = '0;
                exp_s_addr = '0; exp_s_wdata = '0; exp_s_wstrb = '0;
                mdl_pend = 1'b0; mdl_eaddr = '0;
                #1;
                chk("rst_mid_s_valid", 32'(s_valid), 32'd0);
                chk("rst_mid_m_ready", 32'(m_ready), 32'd0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            drive_noise();
            if (!is_err) begin
                if (is_to) s_ready[idx] = (k > TO + 1);
                else       s_ready[idx] = (k == lat + 1);
                if (fix_rd) s_rdata[32*idx +: 32] = rd;
                if (!is_to && k == lat + 1)
                    resp_data = (wstrb != 4'd0) ? 32'd0 : s_rdata[32*idx +: 32];
            end
        end
        // master only sees m_ready at the next edge and keeps m_valid up until then
        model_step(1'b0, '0);
        exp_m_ready = 1'b0;
        exp_s_valid = '0;
        @(negedge clk);
        m_valid = 1'b0;
        drive_noise();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        int lat;
        repeat (3) @(negedge clk);
        chk("reset_m_ready", 32'(m_ready), 32'd0);
        chk("reset_s_valid", 32'(s_valid), 32'd0);
        chk("reset_m_rdata", m_rdata, 32'd0);
        reset = 1'b0;
        idle(2);

        // read slave1, ready after 2 cycles
        sv_high = 0; last_sv = '0;
        do_txn(32'h0300_0104, 4'd0, 32'd0, 2, 1'b1, 32'h1234_5678, 0);
        chk("dir_read_rdata", m_rdata, 32'h1234_5678);
        chk("dir_read_sel", 32'(last_sv), 32'h2);
        chk("dir_read_sv_cycles", sv_high, 3);
        idle(2);

        // write slave0
        sv_high = 0; last_sv = '0;
        do_txn(32'h0300_0008, 4'b0011, 32'hA5A5_A5A5, 1, 1'b0, 32'd0, 0);
        chk("dir_write_addr", s_addr, 32'h0300_0008);
        chk("dir_write_data", s_wdata, 32'hA5A5_A5A5);
        chk("dir_write_strb", 32'(s_wstrb), 32'h3);
        chk("dir_write_rdata", m_rdata, 32'd0);
        chk("dir_write_sel", 32'(last_sv), 32'h1);
        idle(1);

        // unpopulated window
        sv_high = 0;
        do_txn(32'h0300_0300, 4'd0, 32'd0, 0, 1'b0, 32'd0, 0);
        chk("dir_decerr_sv_cycles", sv_high, 0);
        chk("dir_decerr_rdata", m_rdata, 32'hBADB_AD00);
        chk("dir_decerr_eaddr", err_addr, ERRLOG ? 32'h0300_0300 : 32'd0);
        idle(1);

        // slave2 never ready
        sv_high = 0;
        do_txn(32'h0300_0200, 4'd0, 32'd0, -1, 1'b0, 32'd0, 0);
        chk("dir_timeout_sv_cycles", sv_high, 256);
        chk("dir_timeout_rdata", m_rdata, 32'hBADB_AD00);
        idle(1);

        // outside region
        sv_high = 0;
        do_txn(32'h0200_0004, 4'd0, 32'd0, 0, 1'b0, 32'd0, 0);
        chk("dir_miss_sv_cycles", sv_high, 0);
        chk("dir_miss_rdata_held", m_rdata, 32'hBADB_AD00);

        // error log: two errors logged, clear, third error
        chk("dir_log_first", err_addr, ERRLOG ? 32'h0300_0300 : 32'd0);
        chk("dir_log_pend", 32'(err_pending), ERRLOG ? 32'd1 : 32'd0);
        pulse_clr();
        idle(1);
        chk("dir_log_cleared", 32'(err_pending), 32'd0);
        do_txn(32'h0300_0310, 4'hF, 32'h1111_2222, 0, 1'b0, 32'd0, 0);
        chk("dir_log_third", err_addr, ERRLOG ? 32'h0300_0310 : 32'd0);
        idle(1);

        // reset during REQ
        do_txn(32'h0300_0204, 4'd0, 32'd0, -1, 1'b0, 32'd0, 4);
        idle(2);

        // randomized traffic
        clr_noise = 1'b1;
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 19))
                0, 1:    a = 32'h0200_0000 | ($urandom & 32'h0000_FFFC);
                2:       a = $urandom & 32'hFFFF_FFFC;
                3, 4:    a = BASE | (32'd3 << SAW) | ($urandom & 32'hFC);
                default: a = BASE | (32'($urandom_range(0, NS - 1)) << SAW) | ($urandom & 32'hFC);
            endcase
            lat = ($urandom_range(0, 39) == 0) ? -1 : int'($urandom_range(0, 5));
            do_txn(a, ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                   $urandom, lat, 1'b0, 32'd0, 0);
            idle(int'($urandom_range(0, 2)));
        end
        clr_noise = 1'b0;
        err_clr = 1'b0;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
